// File: rtl/a2600_audio_resampler.sv
// TIA audio resampler: box-car decimation of the two 4-bit channels, gain with saturation,
// optional one-pole low-pass (enabled by defining A2600_AUD_LPF_EN), one strobe per output sample.
module a2600_audio_resampler #(
    parameter int SAMPLE_DIV = 149,
    parameter int GAIN       = 29,
    parameter int FILT_SHIFT = 3
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [3:0]  aud_ch0,
    input  logic [3:0]  aud_ch1,
    input  logic        mono,
    output logic [15:0] audio_l,
    output logic [15:0] audio_r,
    output logic        sample_stb
);

    localparam int ACC_W = 4 + $clog2(SAMPLE_DIV);
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int PRD_W = ACC_W + 32;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    function automatic logic [15:0] sat_gain(input logic [ACC_W-1:0] sum);
        logic [PRD_W-1:0] prod;
        prod = PRD_W'(sum) * PRD_W'(GAIN);
        return (prod > PRD_W'(65535)) ? 16'hFFFF : prod[15:0];
    endfunction

    // Minimum step of +/-1 lets y land exactly on pcm instead of stalling below it.
    function automatic logic [15:0] lpf_step(input logic [15:0] y_old, input logic [15:0] pcm);
        logic signed [17:0] d;
        logic signed [17:0] s;
        logic signed [17:0] y_new;
        d = $signed({2'b00, pcm}) - $signed({2'b00, y_old});
        s = d >>> FILT_SHIFT;
        if (s == 18'sd0 && d != 18'sd0) s = d[17] ? -18'sd1 : 18'sd1;
        y_new = $signed({2'b00, y_old}) + s;
        return y_new[15:0];
    endfunction

    logic [4:0]       mix;
    logic [3:0]       x_l, x_r;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [ACC_W-1:0] snap_l_p0_q, snap_l_p0_d, snap_r_p0_q, snap_r_p0_d;
    logic             vld_p0_q, vld_p0_d;
    logic [15:0]      pcm_l_p1_q, pcm_l_p1_d, pcm_r_p1_q, pcm_r_p1_d;
    logic             vld_p1_q, vld_p1_d;
    logic [15:0]      audio_l_p2_q, audio_l_p2_d, audio_r_p2_q, audio_r_p2_d;
    logic             vld_p2_q, vld_p2_d;

    always_comb begin
        mix = {1'b0, aud_ch0} + {1'b0, aud_ch1} + 5'd1;
        x_l = mono ? mix[4:1] : aud_ch0;
        x_r = mono ? mix[4:1] : aud_ch1;

        // Stage A: window accumulate, snapshot on the terminal ce
        cnt_d       = cnt_q;
        acc_l_d     = acc_l_q;
        acc_r_d     = acc_r_q;
        snap_l_p0_d = snap_l_p0_q;
        snap_r_p0_d = snap_r_p0_q;
        vld_p0_d    = 1'b0;
        if (ce) begin
            if (cnt_q == CNT_LAST) begin
                snap_l_p0_d = acc_l_q + ACC_W'(x_l);
                snap_r_p0_d = acc_r_q + ACC_W'(x_r);
                acc_l_d     = '0;
                acc_r_d     = '0;
                cnt_d       = '0;
                vld_p0_d    = 1'b1;
            end else begin
                acc_l_d = acc_l_q + ACC_W'(x_l);
                acc_r_d = acc_r_q + ACC_W'(x_r);
                cnt_d   = cnt_q + 1'b1;
            end
        end

        // Stage B: gain and saturate, independent of ce
        vld_p1_d   = vld_p0_q;
        pcm_l_p1_d = vld_p0_q ? sat_gain(snap_l_p0_q) : pcm_l_p1_q;
        pcm_r_p1_d = vld_p0_q ? sat_gain(snap_r_p0_q) : pcm_r_p1_q;

        // Stage C: output register doubles as the filter state y
        vld_p2_d     = vld_p1_q;
        audio_l_p2_d = audio_l_p2_q;
        audio_r_p2_d = audio_r_p2_q;
        if (vld_p1_q) begin
`ifdef A2600_AUD_LPF_EN
            audio_l_p2_d = lpf_step(audio_l_p2_q, pcm_l_p1_q);
            audio_r_p2_d = lpf_step(audio_r_p2_q, pcm_r_p1_q);
`else
            audio_l_p2_d = pcm_l_p1_q;
            audio_r_p2_d = pcm_r_p1_q;
`endif
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            snap_l_p0_q  <= '0;
            snap_r_p0_q  <= '0;
            vld_p0_q     <= 1'b0;
            pcm_l_p1_q   <= '0;
            pcm_r_p1_q   <= '0;
            vld_p1_q     <= 1'b0;
            audio_l_p2_q <= '0;
            audio_r_p2_q <= '0;
            vld_p2_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_l_q      <= acc_l_d;
            acc_r_q      <= acc_r_d;
            snap_l_p0_q  <= snap_l_p0_d;
            snap_r_p0_q  <= snap_r_p0_d;
            vld_p0_q     <= vld_p0_d;
            pcm_l_p1_q   <= pcm_l_p1_d;
            pcm_r_p1_q   <= pcm_r_p1_d;
            vld_p1_q     <= vld_p1_d;
            audio_l_p2_q <= audio_l_p2_d;
            audio_r_p2_q <= audio_r_p2_d;
            vld_p2_q     <= vld_p2_d;
        end
    end

    assign audio_l    = audio_l_p2_q;
    assign audio_r    = audio_r_p2_q;
    assign sample_stb = vld_p2_q;

endmodule

// File: tb/tb_a2600_audio_resampler.sv
// Bench for a2600_audio_resampler: vector table, hand sequences and a randomized run
// against a window-queue reference model.
module tb_a2600_audio_resampler;

    localparam int SAMPLE_DIV = 149;
    localparam int GAIN       = 29;
    localparam int FILT_SHIFT = 3;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce      = 1'b0;
    logic        mono    = 1'b0;
    logic [3:0]  aud_ch0 = 4'd0;
    logic [3:0]  aud_ch1 = 4'd0;
    logic [15:0] audio_l, audio_r, g30_l, g30_r;
    logic        sample_stb, g30_stb;

    always #5 clk_sys = ~clk_sys;

    a2600_audio_resampler dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .aud_ch0(aud_ch0), .aud_ch1(aud_ch1),
        .mono(mono), .audio_l(audio_l), .audio_r(audio_r), .sample_stb(sample_stb)
    );

    a2600_audio_resampler #(.GAIN(30)) dut_g30 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .aud_ch0(aud_ch0), .aud_ch1(aud_ch1),
        .mono(mono), .audio_l(g30_l), .audio_r(g30_r), .sample_stb(g30_stb)
    );

    typedef struct {
        int at;
        int pl;
        int pr;
    } pend_t;

    typedef struct {
        int ch0;
        int ch1;
        bit mono;
        int ce_div;
        int pcm_l;
        int pcm_r;
        int period;
    } vec_t;

    int    checks = 0;
    int    errors = 0;
    int    edge_cnt = 0;
    pend_t pend[$];
    int    win_l[$];
    int    win_r[$];
    int    y_l = 0, y_r = 0, exp_l = 0, exp_r = 0;
    bit    exp_stb = 1'b0;
    int    ce_div = 1;
    int    ce_phase = 0;

    function automatic int lpf(input int y, input int pcm);
        int d, s;
        d = pcm - y;
        s = d >>> FILT_SHIFT;
        if (s == 0 && d != 0) s = (d > 0) ? 1 : -1;
        return y + s;
    endfunction

    function automatic int out_of(input int y, input int pcm);
`ifdef A2600_AUD_LPF_EN
        return lpf(y, pcm);
`else
        return pcm + 0 * y;
`endif
    endfunction

    function automatic int pcm_of(input int sum, input int gain);
        int p;
        p = sum * gain;
        return (p > 65535) ? 65535 : p;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        int xl, xr, sl, sr;
        @(posedge clk_sys);
        #1;
        edge_cnt++;
        if (!reset_n) begin
            win_l.delete();
            win_r.delete();
            pend.delete();
            y_l = 0; y_r = 0; exp_l = 0; exp_r = 0; exp_stb = 1'b0;
        end else begin
            exp_stb = 1'b0;
            if (pend.size() > 0 && pend[0].at == edge_cnt) begin
                y_l = out_of(y_l, pend[0].pl);
                y_r = out_of(y_r, pend[0].pr);
                exp_l = y_l; exp_r = y_r; exp_stb = 1'b1;
                void'(pend.pop_front());
            end
            if (ce) begin
                xl = mono ? (int'(aud_ch0) + int'(aud_ch1) + 1) / 2 : int'(aud_ch0);
                xr = mono ? (int'(aud_ch0) + int'(aud_ch1) + 1) / 2 : int'(aud_ch1);
                win_l.push_back(xl);
                win_r.push_back(xr);
                if (win_l.size() == SAMPLE_DIV) begin
                    sl = 0; sr = 0;
                    foreach (win_l[i]) sl += win_l[i];
                    foreach (win_r[i]) sr += win_r[i];
                    pend.push_back('{edge_cnt + 2, pcm_of(sl, GAIN), pcm_of(sr, GAIN)});
                    win_l.delete();
                    win_r.delete();
                end
            end
        end
        checks++;
        if (sample_stb !== exp_stb || audio_l !== 16'(exp_l) || audio_r !== 16'(exp_r)) begin
            errors++;
            $display("FAIL model edge=%0d actual stb=%0d l=%0d r=%0d required stb=%0d l=%0d r=%0d",
                     edge_cnt, sample_stb, audio_l, audio_r, exp_stb, exp_l, exp_r);
        end
        if (ce_div > 0) begin
            ce_phase = (ce_phase + 1) % ce_div;
            ce = (ce_phase == 0);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        ce_phase = 0;
        if (ce_div > 0) ce = 1'b1;
    endtask

    task automatic wait_stb(input int max, output int at);
        int n;
        at = -1;
        n = 0;
        while (at < 0 && n < max) begin
            tick();
            n++;
            if (sample_stb) at = edge_cnt;
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout actual=none required=strobe within %0d clocks", max);
        end
    endtask

    vec_t tbl[7];
    int   vals[110];

    initial begin
        int at, at2, first_ce, nonmono;

        tbl[0] = '{15, 0, 1'b0, 1, 64815, 0, 149};
        tbl[1] = '{15, 0, 1'b1, 1, 34568, 34568, 149};
        tbl[2] = '{15, 0, 1'b0, 2, 64815, 0, 298};
        tbl[3] = '{0, 15, 1'b0, 1, 0, 64815, 149};
        tbl[4] = '{7, 3, 1'b1, 1, 21605, 21605, 149};
        tbl[5] = '{9, 4, 1'b0, 1, 38889, 17284, 149};
        tbl[6] = '{0, 0, 1'b0, 1, 0, 0, 149};

        // Reset with random inputs, then first-sample latency
        ce_div = 0;
        aud_ch0 = 4'($urandom_range(0, 15));
        aud_ch1 = 4'($urandom_range(0, 15));
        mono = 1'($urandom_range(0, 1));
        ce = 1'b1;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("reset_audio_l", int'(audio_l), 0);
            check("reset_audio_r", int'(audio_r), 0);
            check("reset_stb", int'(sample_stb), 0);
        end
        ce_div = 1;
        reset_n = 1'b1;
        ce = 1'b1;
        ce_phase = 0;
        first_ce = edge_cnt + 1;
        wait_stb(400, at);
        check("first_latency", at - first_ce, 150);

        for (int v = 0; v < 7; v++) begin
            aud_ch0 = 4'(tbl[v].ch0);
            aud_ch1 = 4'(tbl[v].ch1);
            mono = tbl[v].mono;
            ce_div = tbl[v].ce_div;
            do_reset();
            wait_stb(2 * SAMPLE_DIV * tbl[v].ce_div + 10, at);
            check("vec_first_l", int'(audio_l), out_of(0, tbl[v].pcm_l));
            check("vec_first_r", int'(audio_r), out_of(0, tbl[v].pcm_r));
            wait_stb(2 * SAMPLE_DIV * tbl[v].ce_div + 10, at2);
            check("vec_period", at2 - at, tbl[v].period);
        end

        // Long run toward steady state with ch0 full scale
        aud_ch0 = 4'd15; aud_ch1 = 4'd0; mono = 1'b0; ce_div = 1;
        do_reset();
        nonmono = 0;
        for (int k = 0; k < 110; k++) begin
            wait_stb(400, at);
            vals[k] = int'(audio_l);
            if (k > 0 && vals[k] < vals[k-1]) nonmono++;
        end
`ifdef A2600_AUD_LPF_EN
        check("lpf_step0", vals[0], 8101);
        check("lpf_step1", vals[1], 15190);
`else
        check("pass_step0", vals[0], 64815);
        check("pass_step1", vals[1], 64815);
`endif
        check("monotonic_violations", nonmono, 0);
        check("settled_value", vals[109], 64815);

        // Saturating gain on the GAIN=30 instance
        aud_ch0 = 4'd15; aud_ch1 = 4'd0; mono = 1'b0; ce_div = 1;
        do_reset();
        wait_stb(400, at);
        check("g30_stb", int'(g30_stb), 1);
        check("g30_sat_l", int'(g30_l), out_of(0, 65535));
        check("g30_r", int'(g30_r), 0);

        // One-clock reset in the middle of a window
        do_reset();
        wait_stb(400, at);
        for (int i = 0; i < 73; i++) tick();
        reset_n = 1'b0;
        #2;
        check("midreset_l", int'(audio_l), 0);
        check("midreset_r", int'(audio_r), 0);
        check("midreset_stb", int'(sample_stb), 0);
        tick();
        reset_n = 1'b1;
        first_ce = edge_cnt + 1;
        wait_stb(400, at);
        check("midreset_latency", at - first_ce, 150);
        check("midreset_no_leak", int'(audio_l), out_of(0, 64815));

        // Randomized inputs, gated ce, mode flips
        ce_div = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            aud_ch0 = 4'($urandom_range(0, 15));
            aud_ch1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) mono = ~mono;
            ce = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
